// File: rtl/bank_cmd_arbiter.sv
// Round-robin command arbiter for bank requesters.
// Each grant is offered until the bus accepts it or the requester withdraws.
// Every accepted grant is followed by a fixed idle gap.
module bank_cmd_arbiter #(
    parameter int unsigned NUM_BNK_TOT = 16,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BNK_TOT-1:0] req_i,
    input  logic                   ready_i,
    output logic [NUM_BNK_TOT-1:0] grant_o,
    output logic                   valid_o,
    output logic [3:0]             grant_idx_o,
    output logic [3:0]             ptr_o,
    output logic                   busy_o
);

    localparam logic [3:0] LastIdx = 4'(NUM_BNK_TOT - 1);
    localparam logic [3:0] GapInit = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [NUM_BNK_TOT-1:0] OneBit = NUM_BNK_TOT'(1);

    typedef enum logic [1:0] {StIdle, StOffer, StGap} state_e;

    state_e                   state_q, state_d;
    logic [NUM_BNK_TOT-1:0]   grant_q, grant_d;
    logic                     valid_q, valid_d;
    logic [3:0]               idx_q, idx_d;
    logic [3:0]               ptr_q, ptr_d;
    logic [3:0]               gap_q, gap_d;

    logic [2*NUM_BNK_TOT-1:0] req_dbl;
    logic [NUM_BNK_TOT-1:0]   req_rot;
    logic [4:0]               sel_sum;
    logic [3:0]               sel_idx;
    logic                     sel_found;

    // Pick the first requester at or cyclically above ptr by rotating req so ptr lands on bit 0.
    always_comb begin
        req_dbl   = {req_i, req_i} >> ptr_q;
        req_rot   = req_dbl[NUM_BNK_TOT-1:0];
        sel_found = 1'b0;
        sel_sum   = 5'd0;
        for (int j = 0; j < int'(NUM_BNK_TOT); j++) begin
            if (!sel_found && req_rot[j]) begin
                sel_found = 1'b1;
                sel_sum   = {1'b0, ptr_q} + 5'(j);
            end
        end
        // Explicit wrap keeps non-power-of-two bank counts correct.
        if (sel_sum >= 5'(NUM_BNK_TOT)) begin
            sel_sum = sel_sum - 5'(NUM_BNK_TOT);
        end
        sel_idx = sel_sum[3:0];
    end

    // Next-state logic; every register holds unless a transition says otherwise.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    grant_d = OneBit << sel_idx;
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (valid_q && ready_i) begin
                    ptr_d   = (idx_q == LastIdx) ? 4'd0 : idx_q + 4'd1;
                    valid_d = 1'b0;
                    grant_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        gap_d   = GapInit;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!(|(req_i & grant_q))) begin
                    // Requester withdrew before acceptance: drop the offer, keep ptr.
                    valid_d = 1'b0;
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= 4'd0;
            ptr_q   <= 4'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
        end
    end

    assign grant_o     = grant_q;
    assign valid_o     = valid_q;
    assign grant_idx_o = idx_q;
    assign ptr_o       = ptr_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed bench for bank_cmd_arbiter: 16 banks / gap 2, plus 5 banks / gap 0.
module tb_bank_cmd_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] req0;
    logic        ready0;
    logic [15:0] grant0;
    logic        valid0;
    logic [3:0]  idx0;
    logic [3:0]  ptr0;
    logic        busy0;

    logic [4:0]  req1;
    logic        ready1;
    logic [4:0]  grant1;
    logic        valid1;
    logic [3:0]  idx1;
    logic [3:0]  ptr1;
    logic        busy1;

    int checks = 0;
    int errors = 0;

    bank_cmd_arbiter #(.NUM_BNK_TOT(16), .GAP_CYCLES(2)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req0),
        .ready_i    (ready0),
        .grant_o    (grant0),
        .valid_o    (valid0),
        .grant_idx_o(idx0),
        .ptr_o      (ptr0),
        .busy_o     (busy0)
    );

    bank_cmd_arbiter #(.NUM_BNK_TOT(5), .GAP_CYCLES(0)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req1),
        .ready_i    (ready1),
        .grant_o    (grant1),
        .valid_o    (valid1),
        .grant_idx_o(idx1),
        .ptr_o      (ptr1),
        .busy_o     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic v, input logic [15:0] g,
                        input logic [3:0] i, input logic [3:0] p, input logic b);
        chk({tag, "_valid"}, 32'(valid0), 32'(v));
        chk({tag, "_grant"}, 32'(grant0), 32'(g));
        chk({tag, "_idx"},   32'(idx0),   32'(i));
        chk({tag, "_ptr"},   32'(ptr0),   32'(p));
        chk({tag, "_busy"},  32'(busy0),  32'(b));
    endtask

    initial begin
        logic [15:0] eg;
        logic [4:0]  eg1;
        rst_n  = 1'b0;
        req0   = '0;
        ready0 = 1'b0;
        req1   = '0;
        ready1 = 1'b0;
        step();
        step();
        chk0("reset", 1'b0, 16'h0, 4'd0, 4'd0, 1'b0);
        rst_n = 1'b1;

        // Single request at ptr 0, first edge after reset release arbitrates.
        req0   = 16'h0001;
        ready0 = 1'b1;
        step();
        chk0("single_offer", 1'b1, 16'h0001, 4'd0, 4'd0, 1'b1);
        req0 = '0;
        step();
        chk0("single_xfer", 1'b0, 16'h0, 4'd0, 4'd1, 1'b1);
        step();
        chk0("single_gap2", 1'b0, 16'h0, 4'd0, 4'd1, 1'b1);
        step();
        chk0("single_idle", 1'b0, 16'h0, 4'd0, 4'd1, 1'b0);

        // Wrap: ptr 1 with banks 15 and 0 requesting.
        req0 = 16'h8001;
        step();
        chk0("wrap_offer15", 1'b1, 16'h8000, 4'd15, 4'd1, 1'b1);
        step();
        chk0("wrap_xfer15", 1'b0, 16'h0, 4'd15, 4'd0, 1'b1);
        step();
        step();
        chk0("wrap_idle", 1'b0, 16'h0, 4'd15, 4'd0, 1'b0);
        step();
        chk0("wrap_offer0", 1'b1, 16'h0001, 4'd0, 4'd0, 1'b1);
        req0 = '0;
        step();
        chk0("wrap_xfer0", 1'b0, 16'h0, 4'd0, 4'd1, 1'b1);
        step();
        step();

        // Backpressure, foreign request during offer, then withdrawal.
        ready0 = 1'b0;
        req0   = 16'h0008;
        step();
        chk0("bp_offer3", 1'b1, 16'h0008, 4'd3, 4'd1, 1'b1);
        req0 = 16'h000A;
        for (int k = 0; k < 5; k++) begin
            step();
            chk0("bp_hold", 1'b1, 16'h0008, 4'd3, 4'd1, 1'b1);
        end
        req0 = 16'h0002;
        step();
        chk0("withdraw", 1'b0, 16'h0, 4'd3, 4'd1, 1'b0);
        step();
        chk0("rearb_offer1", 1'b1, 16'h0002, 4'd1, 4'd1, 1'b1);
        ready0 = 1'b1;
        req0   = '0;
        step();
        chk0("rearb_xfer1", 1'b0, 16'h0, 4'd1, 4'd2, 1'b1);

        // Reset asserted mid-gap, between edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk0("rst_gap_async", 1'b0, 16'h0, 4'd0, 4'd0, 1'b0);
        step();
        chk0("rst_gap_held", 1'b0, 16'h0, 4'd0, 4'd0, 1'b0);
        rst_n  = 1'b1;
        req0   = 16'hFFFF;
        ready0 = 1'b1;

        // Saturation: one grant every 4 cycles, banks 0..15 then 0.
        for (int k = 0; k < 17; k++) begin
            eg = 16'h0001 << (k % 16);
            step();
            chk0("sat_offer", 1'b1, eg, 4'(k % 16), 4'(k % 16), 1'b1);
            for (int j = 0; j < 3; j++) begin
                step();
                chk("sat_gap_valid", 32'(valid0), 32'd0);
                chk("sat_gap_grant", 32'(grant0), 32'd0);
            end
        end
        step();
        chk0("sat_offer1", 1'b1, 16'h0002, 4'd1, 4'd1, 1'b1);

        // Reset mid-offer clears the pending grant at once.
        #3;
        rst_n = 1'b0;
        #1;
        chk0("rst_offer_async", 1'b0, 16'h0, 4'd0, 4'd0, 1'b0);
        step();
        rst_n  = 1'b1;
        req0   = '0;
        ready0 = 1'b0;

        // Five banks, no gap: grant every 2 cycles with wrap 4 -> 0.
        req1   = 5'h1F;
        ready1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            eg1 = 5'h01 << (k % 5);
            step();
            chk("n5_valid", 32'(valid1), 32'd1);
            chk("n5_grant", 32'(grant1), 32'(eg1));
            chk("n5_idx",   32'(idx1),   32'(k % 5));
            chk("n5_ptr",   32'(ptr1),   32'(k % 5));
            step();
            chk("n5_xfer_valid", 32'(valid1), 32'd0);
            chk("n5_xfer_ptr",   32'(ptr1),   32'((k + 1) % 5));
            chk("n5_xfer_busy",  32'(busy1),  32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
